serial_complement_sub_ctrl: RTL and testbench



---
 rtl/serial_complement_sub_ctrl.sv | 95 +++++++++
 tb/tb_serial_complement_sub_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_complement_sub_ctrl.sv
// serial_complement_sub_ctrl: bit-serial two's-complement negate (0 + ~A + 1) or subtract (A + ~B + 1),
// one full-adder cell plus a carry flip-flop, LSB first, start/ready/done handshake.
module serial_complement_sub_ctrl #(
  parameter int WIDTH = 6,
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             borrow,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic c, op_r, x, y, s, cn, last;
  assign x = op_r & sa[0];
  assign y = ~sb[0];
  assign s = x ^ y ^ c;
  assign cn = (x & y) | (c & (x ^ y));
  assign last = cnt == CW'(WIDTH - 1);
  // on the MSB edge c still holds the carry into the MSB, so overflow needs no extra register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
      borrow <= 1'b0;
      overflow <= 1'b0;
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      c <= 1'b0;
      op_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          state <= RUN;
          ready <= 1'b0;
          busy <= 1'b1;
          sa <= a;
          sb <= op ? b : a;
          op_r <= op;
          c <= 1'b1;
          cnt <= '0;
          result <= '0;
          carry_out <= 1'b0;
          borrow <= 1'b0;
          overflow <= 1'b0;
        end
        RUN: if (abort) begin
          state <= IDLE;
          ready <= 1'b1;
          busy <= 1'b0;
          result <= '0;
          carry_out <= 1'b0;
          borrow <= 1'b0;
          overflow <= 1'b0;
        end else begin
          result <= {s, result[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          c <= cn;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            carry_out <= cn;
            overflow <= c ^ cn;
            borrow <= op_r & ~cn;
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_complement_sub_ctrl.sv
// tb_serial_complement_sub_ctrl: scoreboard bench for the bit-serial negate/subtract controller.
module tb_serial_complement_sub_ctrl;
  localparam int W = 6;
  typedef struct packed {
    logic [W-1:0] r;
    logic co, bo, ov;
  } exp_t;
  logic clk, reset, start, abort, op;
  logic [W-1:0] a, b, result;
  logic ready, busy, done, carry_out, borrow, overflow;
  int checks = 0, errors = 0;
  exp_t sb_q[$];

  serial_complement_sub_ctrl #(.WIDTH(W), .CW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .borrow(borrow), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t m;
    logic [W:0] sum;
    logic [W-1:0] xv, yv;
    xv = o ? av : '0;
    yv = ~(o ? bv : av);
    sum = {1'b0, xv} + {1'b0, yv} + 1'b1;
    m.r = sum[W-1:0];
    m.co = sum[W];
    m.bo = o & ~sum[W];
    m.ov = (xv[W-1] == yv[W-1]) && (m.r[W-1] != xv[W-1]);
    return m;
  endfunction

  // called at a negedge with the DUT idle; returns at the negedge after the accepting edge
  task automatic issue(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %b want 1", ready);
    end
    sb_q.push_back(model(o, av, bv));
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = ~o; a = W'($urandom); b = W'($urandom);
  endtask

  task automatic collect(input logic pulse);
    int n = 0, busy_n = 0;
    bit got = 0;
    exp_t e;
    while (!got && n < W + 4) begin
      n++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) got = 1;
      else begin
        start = pulse && (n == 2);
        @(negedge clk);
        start = 1'b0;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout got none after %0d cycles want done", n);
      return;
    end
    checks++;
    if (n != W + 1 || busy_n != W) begin
      errors++;
      $display("FAIL latency got done_cycle=%0d busy=%0d want %0d/%0d", n, busy_n, W + 1, W);
    end
    checks++;
    if ({result, carry_out, borrow, overflow} !== e) begin
      errors++;
      $display("FAIL result got r=%b co=%b bo=%b ov=%b want r=%b co=%b bo=%b ov=%b",
               result, carry_out, borrow, overflow, e.r, e.co, e.bo, e.ov);
    end
    start = pulse;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || {result, carry_out, borrow, overflow} !== e) begin
      errors++;
      $display("FAIL hold got done=%b ready=%b busy=%b r=%b want 0/1/0 r=%b", done, ready, busy, result, e.r);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after got ready=%b busy=%b done=%b want 1/0/0", ready, busy, done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, busy, done, result, carry_out, borrow, overflow} !== {3'b100, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset got ready=%b busy=%b done=%b r=%b flags=%b%b%b want 1/0/0 r=0 flags=000",
               ready, busy, done, result, carry_out, borrow, overflow);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_negate;
    issue(1'b0, 6'b001010, 6'b000000); collect(1'b0);
    issue(1'b0, 6'b000000, 6'b111111); collect(1'b0);
    issue(1'b0, 6'b100000, 6'b000000); collect(1'b0);
  endtask

  task automatic test_subtract;
    issue(1'b1, 6'b000101, 6'b000011); collect(1'b0);
    issue(1'b1, 6'b000011, 6'b000101); collect(1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(1'(i), W'($urandom), W'($urandom)); collect(1'b0);
    end
  endtask

  task automatic test_start_ignored;
    issue(1'b1, 6'b011111, 6'b100000);
    collect(1'b1);
  endtask

  task automatic test_abort;
    issue(1'b0, 6'b000001, 6'b000000);
    void'(sb_q.pop_back());
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL abort got ready=%b busy=%b done=%b r=%b co=%b want 1/0/0 r=0 co=0",
               ready, busy, done, result, carry_out);
    end
    for (int i = 0; i < W + 2; i++) begin
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_quiet got done=%b ready=%b want 0/1", done, ready);
      end
      @(negedge clk);
    end
    issue(1'b0, 6'b000001, 6'b000000); collect(1'b0);
  endtask

  task automatic test_async_reset;
    issue(1'b1, 6'b010101, 6'b000111);
    void'(sb_q.pop_back());
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ready, busy, done, result, carry_out, borrow, overflow} !== {3'b100, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got ready=%b busy=%b done=%b r=%b want 1/0/0 r=0", ready, busy, done, result);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 1'b0; a = 6'b000111;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort got ready=%b busy=%b want 1/0", ready, busy);
    end
    issue(1'b1, 6'b101010, 6'b010101); collect(1'b0);
  endtask

  initial begin
    test_reset();
    test_negate();
    test_subtract();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
